// File: rtl/resp_arb.sv
// resp_arb: shares the single UART_comm transmit path (resp/send_resp/resp_sent)
// among NREQ response sources. Requester 0 has fixed priority; requesters
// 1..NREQ-1 share round-robin. Each response is followed by a GAP_CYC idle gap.
// Optional resp_sent watchdog: define RESP_ARB_TMO_EN to enable (limit TMO_CYC).
module resp_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned TMO_CYC = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_byte,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          resp,
    output logic                send_resp,
    input  logic                resp_sent,
    output logic                busy,
    output logic                tmo_err
);

    localparam int unsigned IW       = $clog2(NREQ);
    localparam logic [7:0]  GAP_LOAD = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_resp, w_resp_nxt;
    logic [IW-1:0]       r_owner, w_owner_nxt;
    logic [IW-1:0]       r_rr_ptr, w_rr_nxt;
    logic [7:0]          r_gap_cnt, w_gap_nxt;
    logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]     r_done, w_done_nxt;
    logic                r_send, w_send_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_tmo_err, w_tmo_nxt;

    logic                w_found;
    logic [IW-1:0]       w_win;
    logic [IW-1:0]       w_cand;
    logic [7:0]          w_byte;

`ifdef RESP_ARB_TMO_EN
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0]       r_tmo_cnt, w_tmo_cnt_nxt;
`else
    logic                w_unused_tmo;
    assign w_unused_tmo = (TMO_CYC == 0);
`endif

    // Winner select: requester 0 first, else round-robin over 1..NREQ-1 after rr_ptr
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        if (req[0]) begin
            w_found = 1'b1;
        end else begin
            for (int k = 0; k < int'(NREQ) - 1; k++) begin
                w_cand = IW'(((int'(r_rr_ptr) + k) % (int'(NREQ) - 1)) + 1);
                if (!w_found && req[w_cand]) begin
                    w_found = 1'b1;
                    w_win   = w_cand;
                end
            end
        end
    end

    // Byte of the selected winner
    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_win == IW'(i)) w_byte = req_byte[8*i +: 8];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_resp_nxt  = r_resp;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_gap_nxt   = r_gap_cnt;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_send_nxt  = 1'b0;
        w_tmo_nxt   = 1'b0;
`ifdef RESP_ARB_TMO_EN
        w_tmo_cnt_nxt = r_tmo_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt      = S_SEND;
                    w_resp_nxt       = w_byte;
                    w_owner_nxt      = w_win;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_send_nxt       = 1'b1;
                    if (w_win != '0) w_rr_nxt = w_win;
                end
            end
            S_SEND: begin
                w_state_nxt = S_WAIT;
`ifdef RESP_ARB_TMO_EN
                w_tmo_cnt_nxt = '0;
`endif
            end
            S_WAIT: begin
                if (resp_sent) begin
                    w_done_nxt[r_owner] = 1'b1;
                    if (GAP_CYC == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end
                end
`ifdef RESP_ARB_TMO_EN
                else if (r_tmo_cnt == TW'(TMO_CYC - 1)) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
                end
`endif
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) w_state_nxt = S_IDLE;
                else                   w_gap_nxt   = r_gap_cnt - 8'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_resp    <= 8'h00;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_gap_cnt <= 8'd0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_send    <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_resp    <= w_resp_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_send    <= w_send_nxt;
            r_busy    <= w_busy_nxt;
            r_tmo_err <= w_tmo_nxt;
        end
    end

`ifdef RESP_ARB_TMO_EN
    // Watchdog counter for cycles spent in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tmo_cnt <= '0;
        else     r_tmo_cnt <= w_tmo_cnt_nxt;
    end
`endif

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign resp      = r_resp;
    assign send_resp = r_send;
    assign busy      = r_busy;
    assign tmo_err   = r_tmo_err;

endmodule
